// File: rtl/pipe_ctrl_pkg.sv
// Shared opcode map, FSM state encoding and control-bundle layout for the control sequencer.
// Latency: none (definitions only).
// Backpressure: not applicable.
package pipe_ctrl_pkg;

  localparam int CTRL_OPC_W = 5;

  // ALU operations occupy 5'h00..5'h07.
  localparam logic [CTRL_OPC_W-1:0] OP_ALU_MAX = 5'h07;
  localparam logic [CTRL_OPC_W-1:0] OP_LDR     = 5'h08;
  localparam logic [CTRL_OPC_W-1:0] OP_STR     = 5'h09;
  localparam logic [CTRL_OPC_W-1:0] OP_LDI     = 5'h0C;
  localparam logic [CTRL_OPC_W-1:0] OP_BEQ     = 5'h10;
  localparam logic [CTRL_OPC_W-1:0] OP_JMP     = 5'h11;
  localparam logic [CTRL_OPC_W-1:0] OP_HALT    = 5'h1F;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_MEM_WAIT,
    ST_FLUSH,
    ST_HALT
  } ctrl_state_t;

  // How the sequencer must treat an accepted instruction.
  typedef enum logic [1:0] {
    K_SINGLE,    // one bundle next cycle, keep issuing
    K_MEM,       // wait for memory before retiring
    K_REDIRECT,  // taken BEQ or JMP: retire then insert bubbles
    K_HALT       // retire then stop accepting
  } op_kind_t;

  typedef struct packed {
    logic [CTRL_OPC_W-1:0] alu_opcode;
    logic                  pc_jmp;
    logic                  pc_beq;
    logic                  reg_we;
    logic                  reg_from_alu;
    logic                  reg_from_mem;
    logic                  acc_we;
    logic                  acc_from_imm;
    logic                  illegal;
  } ctrl_bundle_t;

  function automatic logic is_alu_op(input logic [CTRL_OPC_W-1:0] opc);
    return opc <= OP_ALU_MAX;
  endfunction

endpackage

// File: rtl/pipe_ctrl_decode.sv
// Pure opcode decoder: control bundle, sequencing class and store flag for one instruction.
// Latency: combinational.
// Backpressure: none; the caller decides when the result is used.
module pipe_ctrl_decode
  import pipe_ctrl_pkg::*;
(
  input  logic [CTRL_OPC_W-1:0] opcode,
  input  logic                  acc_zero,
  output ctrl_bundle_t          bundle,
  output op_kind_t              kind,
  output logic                  is_store
);

  // Map the opcode to its control bundle; unknown opcodes become a flagged NOP.
  always_comb begin
    bundle   = '0;
    kind     = K_SINGLE;
    is_store = 1'b0;
    if (is_alu_op(opcode)) begin
      bundle.alu_opcode   = opcode;
      bundle.reg_we       = 1'b1;
      bundle.reg_from_alu = 1'b1;
    end else begin
      case (opcode)
        OP_LDI: begin
          bundle.acc_we       = 1'b1;
          bundle.acc_from_imm = 1'b1;
        end
        OP_LDR: begin
          kind                = K_MEM;
          bundle.reg_we       = 1'b1;
          bundle.reg_from_mem = 1'b1;
        end
        OP_STR: begin
          kind     = K_MEM;
          is_store = 1'b1;
        end
        OP_BEQ: begin
          // Not-taken BEQ retires as a plain NOP bundle.
          if (acc_zero) begin
            kind          = K_REDIRECT;
            bundle.pc_beq = 1'b1;
          end
        end
        OP_JMP: begin
          kind          = K_REDIRECT;
          bundle.pc_jmp = 1'b1;
        end
        OP_HALT: kind = K_HALT;
        default: bundle.illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/pipe_ctrl_seq.sv
// Registered control sequencer between fetch and datapath; optional PIPE_CTRL_PERF_EN adds retire/stall counters.
// Latency: bundle one cycle after accept; LDR/STR retire one cycle after Mem_Ack.
// Backpressure: Instr_Ready low during memory wait, post-redirect flush bubbles and after HALT or timeout.
module pipe_ctrl_seq
  import pipe_ctrl_pkg::*;
#(
  parameter int INSTR_W   = 9,
  parameter int OPC_W     = CTRL_OPC_W,
  parameter int ACC_W     = 8,
  parameter int FLUSH_CYC = 1,
  parameter int MEM_TMO   = 16
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               Instr_Valid,
  input  logic [INSTR_W-1:0] Instruction,
  output logic               Instr_Ready,
  input  logic [ACC_W-1:0]   AccInput,
  input  logic               Mem_Ack,
  output logic               Ctrl_Valid,
  output logic [OPC_W-1:0]   ALU_Opcode,
  output logic               PC_Jmp_Flag,
  output logic               PC_Beq_Flag,
  output logic               Reg_Write_En,
  output logic               Reg_From_ALU,
  output logic               Reg_From_Mem,
  output logic               Acc_Write_En,
  output logic               Acc_From_Imm,
  output logic               Mem_Req,
  output logic               Mem_Write_En,
  output logic               Illegal,
  output logic               Err,
  output logic               Ack
`ifdef PIPE_CTRL_PERF_EN
 ,output logic [15:0]        Retired_Cnt,
  output logic [15:0]        Stall_Cnt
`endif
);

  localparam int TMO_W = (MEM_TMO > 2) ? $clog2(MEM_TMO) : 1;

  ctrl_state_t        state_q, state_d;
  ctrl_bundle_t       out_q, pend_q, nxt_bundle, dec_bundle;
  op_kind_t           dec_kind;
  logic               dec_store, pend_store_q;
  logic               out_vld_q, nxt_vld;
  logic               err_q, ack_q, err_set, ack_set;
  logic [2:0]         flush_cnt_q;
  logic [TMO_W-1:0]   tmo_cnt_q;
  logic               accept, tmo_hit, flush_done;
  logic               instr_unused;

  assign instr_unused = ^Instruction[INSTR_W-CTRL_OPC_W-1:0];

  pipe_ctrl_decode u_decode (
    .opcode   (Instruction[INSTR_W-1 -: CTRL_OPC_W]),
    .acc_zero (AccInput == '0),
    .bundle   (dec_bundle),
    .kind     (dec_kind),
    .is_store (dec_store)
  );

  assign Instr_Ready = (state_q == ST_RUN);
  assign accept      = Instr_Valid & Instr_Ready;
  assign tmo_hit     = (tmo_cnt_q == TMO_W'(MEM_TMO - 1));
  assign flush_done  = (flush_cnt_q == 3'd0);

  // Next state, next output bundle and sticky-flag set conditions.
  always_comb begin
    state_d    = state_q;
    nxt_vld    = 1'b0;
    nxt_bundle = '0;
    err_set    = 1'b0;
    ack_set    = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (accept) begin
          case (dec_kind)
            K_MEM:      state_d = ST_MEM_WAIT;
            K_REDIRECT: state_d = ST_FLUSH;
            K_HALT:     state_d = ST_HALT;
            default:    state_d = ST_RUN;
          endcase
          if (dec_kind != K_MEM) begin
            nxt_vld    = 1'b1;
            nxt_bundle = dec_bundle;
          end
          ack_set = (dec_kind == K_HALT);
        end
      end
      ST_MEM_WAIT: begin
        if (Mem_Ack) begin
          state_d    = ST_RUN;
          nxt_vld    = 1'b1;
          nxt_bundle = pend_q;
        end else if (tmo_hit) begin
          state_d = ST_HALT;
          err_set = 1'b1;
        end
      end
      ST_FLUSH: if (flush_done) state_d = ST_RUN;
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_RUN;
    endcase
  end

  // State, registered bundle and sticky Err/Ack.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= ST_RUN;
      out_vld_q <= 1'b0;
      out_q     <= '0;
      err_q     <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_vld_q <= nxt_vld;
      out_q     <= nxt_bundle;
      err_q     <= err_q | err_set;
      ack_q     <= ack_q | ack_set;
    end
  end

  // Flush bubble down-counter and memory timeout up-counter.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      flush_cnt_q <= 3'd0;
      tmo_cnt_q   <= '0;
    end else begin
      if (state_q == ST_RUN && accept && dec_kind == K_REDIRECT)
        flush_cnt_q <= 3'(FLUSH_CYC - 1);
      else if (state_q == ST_FLUSH && !flush_done)
        flush_cnt_q <= flush_cnt_q - 3'd1;
      if (state_q != ST_MEM_WAIT)
        tmo_cnt_q <= '0;
      else if (!tmo_hit)
        tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
    end
  end

  // Hold the memory op's bundle until Mem_Ack retires it.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pend_q       <= '0;
      pend_store_q <= 1'b0;
    end else if (state_q == ST_RUN && accept && dec_kind == K_MEM) begin
      pend_q       <= dec_bundle;
      pend_store_q <= dec_store;
    end
  end

  assign Ctrl_Valid   = out_vld_q;
  assign ALU_Opcode   = OPC_W'(out_q.alu_opcode);
  assign PC_Jmp_Flag  = out_q.pc_jmp;
  assign PC_Beq_Flag  = out_q.pc_beq;
  assign Reg_Write_En = out_q.reg_we;
  assign Reg_From_ALU = out_q.reg_from_alu;
  assign Reg_From_Mem = out_q.reg_from_mem;
  assign Acc_Write_En = out_q.acc_we;
  assign Acc_From_Imm = out_q.acc_from_imm;
  assign Illegal      = out_q.illegal;
  assign Mem_Req      = (state_q == ST_MEM_WAIT);
  assign Mem_Write_En = Mem_Req & pend_store_q;
  assign Err          = err_q;
  assign Ack          = ack_q;

`ifdef PIPE_CTRL_PERF_EN
  // Saturating retire and stall counters.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Retired_Cnt <= 16'd0;
      Stall_Cnt   <= 16'd0;
    end else begin
      if (out_vld_q && Retired_Cnt != 16'hFFFF)
        Retired_Cnt <= Retired_Cnt + 16'd1;
      if (Instr_Valid && !Instr_Ready && Stall_Cnt != 16'hFFFF)
        Stall_Cnt <= Stall_Cnt + 16'd1;
    end
  end
`else
  // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_pipe_ctrl_seq.sv
// Self-checking bench for pipe_ctrl_seq: directed steps plus a randomized instruction stream.
// Latency: expectations are built per instruction from the opcode rules and stepped cycle by cycle.
// Backpressure: Instr_Valid is held while Instr_Ready is low during HALT to exercise stalls.
module tb_pipe_ctrl_seq;

  localparam int FC  = 3;
  localparam int TMO = 16;

  localparam logic [4:0] B_LDR  = 5'h08;
  localparam logic [4:0] B_STR  = 5'h09;
  localparam logic [4:0] B_LDI  = 5'h0C;
  localparam logic [4:0] B_BEQ  = 5'h10;
  localparam logic [4:0] B_JMP  = 5'h11;
  localparam logic [4:0] B_HALT = 5'h1F;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       Instr_Valid = 1'b0;
  logic [8:0] Instruction = '0;
  logic [7:0] AccInput = '0;
  logic       Mem_Ack = 1'b0;
  logic       Instr_Ready, Ctrl_Valid;
  logic [4:0] ALU_Opcode;
  logic       PC_Jmp_Flag, PC_Beq_Flag, Reg_Write_En, Reg_From_ALU, Reg_From_Mem;
  logic       Acc_Write_En, Acc_From_Imm, Mem_Req, Mem_Write_En, Illegal, Err, Ack;
`ifdef PIPE_CTRL_PERF_EN
  logic [15:0] Retired_Cnt, Stall_Cnt;
`endif

  int   vectors = 0;
  int   miscompares = 0;
  logic m_err = 1'b0, m_ack = 1'b0, m_halt = 1'b0;
  int   e_ret = 0, e_stall = 0;

  always #5 Clk = ~Clk;

  pipe_ctrl_seq #(
    .INSTR_W(9), .OPC_W(5), .ACC_W(8), .FLUSH_CYC(FC), .MEM_TMO(TMO)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Instr_Valid(Instr_Valid), .Instruction(Instruction),
    .Instr_Ready(Instr_Ready), .AccInput(AccInput), .Mem_Ack(Mem_Ack),
    .Ctrl_Valid(Ctrl_Valid), .ALU_Opcode(ALU_Opcode), .PC_Jmp_Flag(PC_Jmp_Flag),
    .PC_Beq_Flag(PC_Beq_Flag), .Reg_Write_En(Reg_Write_En), .Reg_From_ALU(Reg_From_ALU),
    .Reg_From_Mem(Reg_From_Mem), .Acc_Write_En(Acc_Write_En), .Acc_From_Imm(Acc_From_Imm),
    .Mem_Req(Mem_Req), .Mem_Write_En(Mem_Write_En), .Illegal(Illegal), .Err(Err), .Ack(Ack)
`ifdef PIPE_CTRL_PERF_EN
   ,.Retired_Cnt(Retired_Cnt), .Stall_Cnt(Stall_Cnt)
`endif
  );

  // Observed outputs: {ready, valid, alu[4:0], jmp, beq, rwe, ralu, rmem, awe, aimm, ill, mreq, mwe, err, ack}
  function automatic logic [18:0] obs_vec();
    return {Instr_Ready, Ctrl_Valid, ALU_Opcode, PC_Jmp_Flag, PC_Beq_Flag, Reg_Write_En,
            Reg_From_ALU, Reg_From_Mem, Acc_Write_En, Acc_From_Imm, Illegal,
            Mem_Req, Mem_Write_En, Err, Ack};
  endfunction

  function automatic logic [18:0] exp_vec(input logic rdy, input logic [13:0] ctl,
                                          input logic mreq, input logic mwe);
    return {rdy, ctl, mreq, mwe, m_err, m_ack};
  endfunction

  function automatic logic is_def(input logic [4:0] opc);
    return (opc <= 5'h07) || opc == B_LDR || opc == B_STR || opc == B_LDI ||
           opc == B_BEQ || opc == B_JMP || opc == B_HALT;
  endfunction

  // Retiring bundle {valid, alu, jmp, beq, rwe, ralu, rmem, awe, aimm, ill} for an instruction.
  function automatic logic [13:0] exp_ctrl(input logic [4:0] opc, input logic [7:0] acc);
    logic [13:0] v;
    v = '0;
    v[13] = 1'b1;
    if (opc <= 5'h07) begin
      v[12:8] = opc; v[5] = 1'b1; v[4] = 1'b1;
    end else if (opc == B_LDI) begin
      v[2] = 1'b1; v[1] = 1'b1;
    end else if (opc == B_LDR) begin
      v[5] = 1'b1; v[3] = 1'b1;
    end else if (opc == B_BEQ) begin
      v[6] = (acc == 8'h00);
    end else if (opc == B_JMP) begin
      v[7] = 1'b1;
    end else if (!is_def(opc)) begin
      v[0] = 1'b1;
    end
    return v;
  endfunction

  // 0 single-cycle, 1 redirect, 2 memory, 3 halt
  function automatic int op_kind(input logic [4:0] opc, input logic [7:0] acc);
    if (opc == B_JMP || (opc == B_BEQ && acc == 8'h00)) return 1;
    if (opc == B_LDR || opc == B_STR) return 2;
    if (opc == B_HALT) return 3;
    return 0;
  endfunction

  function automatic logic [4:0] pick_undef();
    logic [4:0] o;
    o = 5'($urandom);
    while (is_def(o)) o = 5'($urandom);
    return o;
  endfunction

  task automatic chk(input string tag, input logic [18:0] exp);
    logic [18:0] obs;
    obs = obs_vec();
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

`ifdef PIPE_CTRL_PERF_EN
  task automatic chk_val(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
`endif

  // Present one instruction for exactly one edge (caller guarantees Instr_Ready).
  task automatic drive_accept(input logic [4:0] opc, input logic [7:0] acc);
    Instr_Valid = 1'b1;
    Instruction = {opc, 4'($urandom)};
    AccInput    = acc;
    Mem_Ack     = 1'($urandom);
    @(negedge Clk);
    Instr_Valid = 1'b0;
    Instruction = 9'($urandom);
    AccInput    = 8'($urandom);
    Mem_Ack     = 1'b0;
  endtask

  // Issue one instruction and follow it until the block is ready again (or halted).
  // d = memory ack delay in cycles; d > TMO means memory never answers.
  task automatic issue(input logic [4:0] opc, input logic [7:0] acc, input int d);
    logic [13:0] ctl;
    int k;
    ctl = exp_ctrl(opc, acc);
    k   = op_kind(opc, acc);
    drive_accept(opc, acc);
    case (k)
      0: begin
        chk("single", exp_vec(1'b1, ctl, 1'b0, 1'b0));
        e_ret++;
      end
      1: begin
        chk("redirect", exp_vec(1'b0, ctl, 1'b0, 1'b0));
        e_ret++;
        for (int i = 1; i < FC; i++) begin
          @(negedge Clk);
          chk("flush_bubble", exp_vec(1'b0, '0, 1'b0, 1'b0));
        end
        @(negedge Clk);
        chk("flush_end", exp_vec(1'b1, '0, 1'b0, 1'b0));
      end
      2: begin
        for (int c = 1; c <= TMO; c++) begin
          chk("mem_wait", exp_vec(1'b0, '0, 1'b1, opc == B_STR));
          if (c == d) begin
            Mem_Ack = 1'b1;
            @(negedge Clk);
            Mem_Ack = 1'b0;
            chk("mem_done", exp_vec(1'b1, ctl, 1'b0, 1'b0));
            e_ret++;
            break;
          end
          @(negedge Clk);
          if (c == TMO) begin
            m_err  = 1'b1;
            m_halt = 1'b1;
            chk("mem_timeout", exp_vec(1'b0, '0, 1'b0, 1'b0));
          end
        end
      end
      default: begin
        m_ack  = 1'b1;
        m_halt = 1'b1;
        chk("halt_retire", exp_vec(1'b0, ctl, 1'b0, 1'b0));
        e_ret++;
      end
    endcase
  endtask

  // Idle cycles; v=1 holds Instr_Valid (only used while halted). Mem_Ack is noise here.
  task automatic idle(input int n, input logic v);
    for (int i = 0; i < n; i++) begin
      Instr_Valid = v;
      Instruction = 9'($urandom);
      Mem_Ack     = 1'($urandom);
      @(negedge Clk);
      if (v && m_halt) e_stall++;
      chk("idle", exp_vec(!m_halt, '0, 1'b0, 1'b0));
    end
    Instr_Valid = 1'b0;
    Mem_Ack     = 1'b0;
  endtask

  // Asynchronous reset pulse starting mid-cycle.
  task automatic pulse_reset();
    #2;
    Reset_n     = 1'b0;
    Instr_Valid = 1'b0;
    Mem_Ack     = 1'b0;
    #1;
    m_err = 1'b0; m_ack = 1'b0; m_halt = 1'b0; e_ret = 0; e_stall = 0;
    chk("reset_async", exp_vec(1'b1, '0, 1'b0, 1'b0));
    @(negedge Clk);
    chk("reset_hold", exp_vec(1'b1, '0, 1'b0, 1'b0));
    Reset_n = 1'b1;
    @(negedge Clk);
    chk("post_reset", exp_vec(1'b1, '0, 1'b0, 1'b0));
  endtask

  initial begin
    // Power-on reset
    @(negedge Clk);
    chk("reset_state", exp_vec(1'b1, '0, 1'b0, 1'b0));
    Reset_n = 1'b1;
    idle(1, 1'b0);

    // Back-to-back ALU ops with Instr_Valid held
    issue(5'h01, 8'($urandom), 0);
    issue(5'h02, 8'($urandom), 0);
    issue(5'h03, 8'($urandom), 0);
    idle(1, 1'b0);

    // LDR answered after 3 cycles
    issue(B_LDR, 8'($urandom), 3);
    idle(1, 1'b0);

    // BEQ taken, BEQ not taken, JMP
    issue(B_BEQ, 8'h00, 0);
    issue(B_BEQ, 8'h05, 0);
    idle(1, 1'b0);
    issue(B_JMP, 8'($urandom), 0);

    // Randomized instruction stream
    for (int it = 0; it < 60; it++) begin : rnd_loop
      int r;
      logic [4:0] opc;
      logic [7:0] acc;
      r = int'($urandom_range(0, 8));
      case (r)
        0, 1:    opc = 5'($urandom_range(0, 7));
        2:       opc = B_LDI;
        3:       opc = B_LDR;
        4:       opc = B_STR;
        5:       opc = B_BEQ;
        6:       opc = B_JMP;
        default: opc = pick_undef();
      endcase
      acc = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
      issue(opc, acc, int'($urandom_range(1, TMO)));
      idle(int'($urandom_range(0, 2)), 1'b0);
    end

    // Reset while waiting on memory, then while flushing
    drive_accept(B_LDR, 8'h03);
    chk("rst_memwait_pre", exp_vec(1'b0, '0, 1'b1, 1'b0));
    pulse_reset();
    drive_accept(B_JMP, 8'h00);
    chk("rst_flush_pre", exp_vec(1'b0, exp_ctrl(B_JMP, 8'h00), 1'b0, 1'b0));
    pulse_reset();
    issue(B_LDI, 8'h7E, 0);
    idle(1, 1'b0);

    // STR never acknowledged: sticky Err, no further accepts, reset clears
    issue(B_STR, 8'($urandom), TMO + 1);
    idle(4, 1'b1);
    pulse_reset();

    // Undefined opcode then HALT
    issue(5'h1A, 8'($urandom), 0);
    issue(B_HALT, 8'($urandom), 0);
    idle(5, 1'b1);
`ifdef PIPE_CTRL_PERF_EN
    chk_val("retired_cnt", int'(Retired_Cnt), e_ret);
    chk_val("stall_cnt", int'(Stall_Cnt), e_stall);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
